// File: rtl/pio_poll_master_if.sv
// -----------------------------------------------------------------------------
// pio_poll_master_if
// Avalon-MM read-only bus bundle between the PIO poll master and the
// interconnect.
//   address     [1:0]  word address of the polled register (master -> slave)
//   read               read strobe                          (master -> slave)
//   waitrequest        slave stall                          (slave -> master)
//   readdata    [31:0] read data, bit 0 carries the PIO level (slave -> master)
// -----------------------------------------------------------------------------
interface pio_poll_master_if;
   logic [1:0]  address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address,
      output read,
      input  waitrequest,
      input  readdata
   );

   modport slave (
      input  address,
      input  read,
      output waitrequest,
      output readdata
   );
endinterface

// File: rtl/pio_poll_master.sv
// -----------------------------------------------------------------------------
// pio_poll_master
// Periodically reads a single-bit PIO register over Avalon-MM and turns the
// polled level into a sample stream with rising-edge detection and a
// saturating rising-edge counter.
//
// Ports:
//   clk           system clock (only clock)
//   reset_n       synchronous, active-low reset
//   enable        polling runs while high
//   clear_count   one-cycle request to zero edge_count (beats an increment)
//   bus           Avalon-MM read master (address, read, waitrequest, readdata)
//   sample_value  most recent polled level
//   sample_valid  one-cycle pulse when sample_value has just been updated
//   edge_pulse    one-cycle pulse alongside sample_valid on a rising edge
//   edge_count    saturating rising-edge count
//
// Parameters:
//   POLL_DIV      idle clocks between the end of a poll and the next read
//   READ_LATENCY  cycles from read acceptance to valid readdata (1..4)
//   POLL_ADDR     word address presented while read is high
// -----------------------------------------------------------------------------
module pio_poll_master #(
   parameter int unsigned POLL_DIV     = 1000,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [1:0]  POLL_ADDR    = 2'd0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     clear_count,
   pio_poll_master_if.master        bus,
   output logic                     sample_value,
   output logic                     sample_valid,
   output logic                     edge_pulse,
   output logic [15:0]              edge_count
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REQ       = 2'd1;
   localparam logic [1:0] WAIT_DATA = 2'd2;
   localparam logic [1:0] CAPTURE   = 2'd3;

   localparam logic [15:0] DIV_LAST = 16'(POLL_DIV - 1);
   localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY);

   logic [1:0]  state_reg, state_next;
   logic [15:0] div_cnt_reg, div_cnt_next;
   logic [2:0]  lat_cnt_reg, lat_cnt_next;
   logic        read_reg;
   logic [1:0]  address_reg;
   logic        sample_value_reg;
   logic        sample_valid_reg;
   logic        edge_pulse_reg;
   logic [15:0] edge_count_reg, edge_count_next;
   logic        have_prev_reg;

   logic        capture_now;
   logic        new_bit;
   logic        edge_now;

   // Only bit 0 of the PIO data register is meaningful.
   logic        unused_readdata;
   assign unused_readdata = ^bus.readdata[31:1];

   assign new_bit = bus.readdata[0];

   // Data is taken on the last WAIT_DATA cycle so that sample_value and
   // sample_valid change together on entry to CAPTURE.
   assign capture_now = (state_reg == WAIT_DATA) && (lat_cnt_reg == LAT_LAST);

   // The very first sample after reset has nothing to compare against.
   assign edge_now = capture_now && new_bit && have_prev_reg && !sample_value_reg;

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      lat_cnt_next = lat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (!enable) begin
               div_cnt_next = 16'd0;
            end else if (div_cnt_reg == DIV_LAST) begin
               state_next   = REQ;
               div_cnt_next = 16'd0;
            end else begin
               div_cnt_next = div_cnt_reg + 16'd1;
            end
         end
         REQ: begin
            // A posted read is never withdrawn, even if enable drops.
            if (!bus.waitrequest) begin
               state_next   = WAIT_DATA;
               lat_cnt_next = 3'd1;
            end
         end
         WAIT_DATA: begin
            if (lat_cnt_reg == LAT_LAST) begin
               state_next = CAPTURE;
            end else begin
               lat_cnt_next = lat_cnt_reg + 3'd1;
            end
         end
         CAPTURE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Count follows the registered edge_pulse, so it moves one cycle after the
   // pulse is visible; a coincident clear always wins.
   always_comb begin
      edge_count_next = edge_count_reg;
      if (clear_count) begin
         edge_count_next = 16'd0;
      end else if (edge_pulse_reg && (edge_count_reg != 16'hFFFF)) begin
         edge_count_next = edge_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         div_cnt_reg      <= 16'd0;
         lat_cnt_reg      <= 3'd0;
         read_reg         <= 1'b0;
         address_reg      <= 2'd0;
         sample_value_reg <= 1'b0;
         sample_valid_reg <= 1'b0;
         edge_pulse_reg   <= 1'b0;
         edge_count_reg   <= 16'd0;
         have_prev_reg    <= 1'b0;
      end else begin
         state_reg        <= state_next;
         div_cnt_reg      <= div_cnt_next;
         lat_cnt_reg      <= lat_cnt_next;
         // Bus outputs are decoded from the next state so they are registered
         // yet line up exactly with the REQ state.
         read_reg         <= (state_next == REQ);
         address_reg      <= (state_next == REQ) ? POLL_ADDR : 2'd0;
         sample_valid_reg <= capture_now;
         edge_pulse_reg   <= edge_now;
         edge_count_reg   <= edge_count_next;
         if (capture_now) begin
            sample_value_reg <= new_bit;
            have_prev_reg    <= 1'b1;
         end
      end
   end

   assign bus.read     = read_reg;
   assign bus.address  = address_reg;
   assign sample_value = sample_value_reg;
   assign sample_valid = sample_valid_reg;
   assign edge_pulse   = edge_pulse_reg;
   assign edge_count   = edge_count_reg;

endmodule

// File: tb/tb_pio_poll_master.sv
// -----------------------------------------------------------------------------
// tb_pio_poll_master
// Two instances: unit 0 (POLL_DIV=4, READ_LATENCY=1, POLL_ADDR=3) and
// unit 1 (POLL_DIV=4, READ_LATENCY=3, POLL_ADDR=0). Each poll is checked at
// transaction level against expectations derived from the poll-period formula,
// the edge rule (rising, previous sample exists) and a saturating counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pio_poll_master;

   localparam int         P      = 4;
   localparam int         LAT_A  = 1;
   localparam int         LAT_B  = 3;
   localparam logic [1:0] ADDR_A = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_a, en_a, clr_a, sv_a, sval_a, ep_a;
   logic [15:0] cnt_a;
   logic        rst_b, en_b, clr_b, sv_b, sval_b, ep_b;
   logic [15:0] cnt_b;

   pio_poll_master_if bus_a ();
   pio_poll_master_if bus_b ();

   pio_poll_master #(.POLL_DIV(P), .READ_LATENCY(LAT_A), .POLL_ADDR(ADDR_A)) dut_a (
      .clk(clk), .reset_n(rst_a), .enable(en_a), .clear_count(clr_a),
      .bus(bus_a.master),
      .sample_value(sv_a), .sample_valid(sval_a), .edge_pulse(ep_a), .edge_count(cnt_a)
   );

   pio_poll_master #(.POLL_DIV(P), .READ_LATENCY(LAT_B), .POLL_ADDR(2'd0)) dut_b (
      .clk(clk), .reset_n(rst_b), .enable(en_b), .clear_count(clr_b),
      .bus(bus_b.master),
      .sample_value(sv_b), .sample_valid(sval_b), .edge_pulse(ep_b), .edge_count(cnt_b)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state per unit.
   bit          m_prev [2];
   bit          m_have [2];
   logic [15:0] m_cnt  [2];
   int          last_read  [2];
   int          prev_stall [2];

   logic        o_read, o_sv, o_sval, o_ep;
   logic [1:0]  o_addr;
   logic [15:0] o_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int u);
      if (u == 0) begin
         o_read = bus_a.read; o_addr = bus_a.address; o_sv = sv_a;
         o_sval = sval_a; o_ep = ep_a; o_cnt = cnt_a;
      end else begin
         o_read = bus_b.read; o_addr = bus_b.address; o_sv = sv_b;
         o_sval = sval_b; o_ep = ep_b; o_cnt = cnt_b;
      end
   endtask

   task automatic set_ws(input int u, input logic v);
      if (u == 0) bus_a.waitrequest = v; else bus_b.waitrequest = v;
   endtask

   task automatic set_en(input int u, input logic v);
      if (u == 0) en_a = v; else en_b = v;
   endtask

   task automatic set_clr(input int u, input logic v);
      if (u == 0) clr_a = v; else clr_b = v;
   endtask

   task automatic model_reset(input int u);
      m_prev[u] = 1'b0; m_have[u] = 1'b0; m_cnt[u] = 16'd0; prev_stall[u] = 0;
   endtask

   task automatic chk_reset(input int u);
      sample(u);
      chk("rst_read",  32'(o_read), 0);
      chk("rst_addr",  32'(o_addr), 0);
      chk("rst_value", 32'(o_sv),   0);
      chk("rst_valid", 32'(o_sval), 0);
      chk("rst_edge",  32'(o_ep),   0);
      chk("rst_count", 32'(o_cnt),  0);
   endtask

   // One complete poll. gap_mode: 0 = no period check, 1 = first read after
   // enable rise (POLL_DIV), 2 = steady-state period after previous poll.
   task automatic poll(input int u, input bit rd, input int stall, input int gap_mode,
                       input bit clr_pulse, input bit drop_en);
      int          n;
      int          lat;
      int          exp_gap;
      int          valid_cyc;
      logic [1:0]  addr;
      logic [31:0] w;
      bit          exp_edge;
      lat     = (u == 0) ? LAT_A : LAT_B;
      addr    = (u == 0) ? ADDR_A : 2'd0;
      exp_gap = (gap_mode == 1) ? P : P + lat + 2 + prev_stall[u];
      w       = $urandom();
      w[0]    = rd;
      if (u == 0) bus_a.readdata = w; else bus_b.readdata = w;
      set_ws(u, stall > 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         sample(u);
         if (!o_read) chk("idle_no_valid", 32'(o_sval), 0);
      end while (!o_read && n < 200);
      chk("read_seen", 32'(o_read), 1);
      if (!o_read) return;
      if (gap_mode != 0) chk("read_period", cyc - last_read[u], exp_gap);
      last_read[u]  = cyc;
      prev_stall[u] = stall;
      chk("read_addr", 32'(o_addr), 32'(addr));
      if (drop_en) set_en(u, 1'b0);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         sample(u);
         chk("stall_read", 32'(o_read), 1);
         chk("stall_addr", 32'(o_addr), 32'(addr));
         if (k == stall - 1) set_ws(u, 1'b0);
      end
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         sample(u);
         chk("wait_quiet", 32'({o_read, o_addr, o_sval}), 0);
      end
      @(negedge clk);
      sample(u);
      valid_cyc = cyc;
      exp_edge  = rd && m_have[u] && !m_prev[u];
      chk("valid_pulse", 32'(o_sval), 1);
      chk("valid_value", 32'(o_sv),   32'(rd));
      chk("valid_edge",  32'(o_ep),   32'(exp_edge));
      chk("valid_read",  32'(o_read), 0);
      m_prev[u] = rd;
      m_have[u] = 1'b1;
      if (clr_pulse) set_clr(u, 1'b1);
      @(negedge clk);
      set_clr(u, 1'b0);
      if (clr_pulse) m_cnt[u] = 16'd0;
      else if (exp_edge && m_cnt[u] != 16'hFFFF) m_cnt[u] = m_cnt[u] + 16'd1;
      sample(u);
      chk("after_valid", 32'(o_sval), 0);
      chk("after_edge",  32'(o_ep),   0);
      chk("edge_count",  32'(o_cnt),  32'(m_cnt[u]));
      $display("poll unit=%0d bit=%0d stall=%0d read_at=%0d valid_at=%0d edge=%0d count=%04h",
               u, rd, stall, last_read[u], valid_cyc, exp_edge, o_cnt);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_a = 1'b0; en_a = 1'b0; clr_a = 1'b0;
      rst_b = 1'b0; en_b = 1'b0; clr_b = 1'b0;
      bus_a.waitrequest = 1'b0; bus_a.readdata = 32'd0;
      bus_b.waitrequest = 1'b0; bus_b.readdata = 32'd0;
      model_reset(0);
      model_reset(1);
      repeat (3) @(negedge clk);
      chk_reset(0);
      chk_reset(1);

      // Unit 0: enable rise, first sample high gives no edge.
      rst_a = 1'b1;
      @(negedge clk);
      en_a = 1'b1;
      last_read[0] = cyc;
      poll(0, 1'b1, 0, 1, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      // 0,1,0,1 -> edges on the 1s.
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b1, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b1, 0, 2, 1'b0, 1'b0);

      // Random levels and short stalls.
      for (int i = 0; i < 16; i++) begin
         poll(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 2, 1'b0, 1'b0);
      end

      // Five-cycle stall, then the stretched period is checked by the next poll.
      poll(0, 1'($urandom_range(0, 1)), 5, 2, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);

      // Saturation: preload the counter just below full scale.
      force dut_a.edge_count_reg = 16'hFFFE;
      @(negedge clk);
      release dut_a.edge_count_reg;
      m_cnt[0] = 16'hFFFE;
      sample(0);
      chk("preload", 32'(o_cnt), 32'hFFFE);
      poll(0, 1'b1, 0, 0, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b1, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b1, 0, 2, 1'b0, 1'b0);
      // Clear coincident with an edge pulse.
      poll(0, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(0, 1'b1, 0, 2, 1'b1, 1'b0);

      // Enable dropped during a stalled request.
      poll(0, 1'b0, 3, 2, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         sample(0);
         chk("disabled_quiet", 32'({o_read, o_sval}), 0);
      end
      en_a = 1'b1;
      last_read[0] = cyc;
      poll(0, 1'b1, 0, 1, 1'b0, 1'b0);

      // Unit 1: longer read latency, then reset in the middle of WAIT_DATA.
      rst_b = 1'b1;
      @(negedge clk);
      en_b = 1'b1;
      last_read[1] = cyc;
      poll(1, 1'b1, 0, 1, 1'b0, 1'b0);
      poll(1, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(1, 1'b1, 1, 2, 1'b0, 1'b0);
      poll(1, 1'b0, 0, 2, 1'b0, 1'b0);
      bus_b.readdata = 32'd1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         sample(1);
      end while (!o_read && n < 200);
      chk("b_read_before_reset", 32'(o_read), 1);
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk_reset(1);
      model_reset(1);
      last_read[1] = cyc;
      poll(1, 1'b1, 0, 1, 1'b0, 1'b0);
      poll(1, 1'b0, 0, 2, 1'b0, 1'b0);
      poll(1, 1'b1, 0, 2, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
